// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the RGB332 -> RGB444 pin expansion.
package vga_timing_pkg;
  localparam int COUNT_WIDTH = 32;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Replicate the top bits so full-scale 3/2-bit values map to full-scale 4-bit.
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction
endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low reset to a chosen idle vector.
module sync_delay_line #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stage_q <= {DEPTH{RESET_VALUE}};
    else        stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters for the sprite stage, sync/DE delayed to
// line up with the returning colour, blanked and registered onto RGB444 pins.
module vga_sync_gen #(
  parameter int COLOR_DELAY = 7,
  parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [31:0] count_h,
  output logic signed [31:0] count_v,
  output logic               frame_start,
  output logic               vblank,
  input  logic [7:0]         color_in,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b
);
  import vga_timing_pkg::*;

  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_STOP  = VS_START + V_SYNC;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  cnt_t        count_h_q, count_h_d, count_v_q, count_v_d;
  logic        frame_start_q, frame_start_d, vblank_q, vblank_d;
  logic        hs_raw, vs_raw, de_raw;
  logic        hs_d, vs_d, de_d;
  logic        vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic [11:0] rgb_q, rgb_d;

  // frame_start/vblank look at the next counts so they land with them.
  always_comb begin
    count_h_d = count_h_q + cnt_t'(1);
    count_v_d = count_v_q;
    if (count_h_q == cnt_t'(H_TOT - 1)) begin
      count_h_d = '0;
      count_v_d = (count_v_q == cnt_t'(V_TOT - 1)) ? '0 : count_v_q + cnt_t'(1);
    end
    frame_start_d = (count_h_d == '0) && (count_v_d == '0);
    vblank_d      = count_v_d >= cnt_t'(V_VISIBLE);
  end

  assign hs_raw = !((count_h_q >= cnt_t'(HS_START)) && (count_h_q < cnt_t'(HS_STOP)));
  assign vs_raw = !((count_v_q >= cnt_t'(VS_START)) && (count_v_q < cnt_t'(VS_STOP)));
  assign de_raw = (count_h_q < cnt_t'(H_VISIBLE)) && (count_v_q < cnt_t'(V_VISIBLE));

  sync_delay_line #(
    .WIDTH       (3),
    .DEPTH       (COLOR_DELAY),
    .RESET_VALUE (3'b110)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({hs_raw, vs_raw, de_raw}),
    .dout  ({hs_d, vs_d, de_d})
  );

  // color_in is don't-care outside the active area; the mux keeps it off the pins.
  always_comb begin
    vga_hs_d = hs_d;
    vga_vs_d = vs_d;
    rgb_d    = de_d ? rgb332_to_444(color_in) : 12'h000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_h_q     <= '0;
      count_v_q     <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      rgb_q         <= '0;
    end else begin
      count_h_q     <= count_h_d;
      count_v_q     <= count_v_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      rgb_q         <= rgb_d;
    end
  end

  assign count_h     = $signed(count_h_q);
  assign count_v     = $signed(count_v_q);
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule
